// File: rtl/io_bus_master_if.sv
// io_bus_master_if: host request/response handshake plus the peripheral
// direction and pattern-select lines driven by io_bus_master.
interface io_bus_master_if #(parameter int DATA_W = 2);
    logic              req_valid, req_ready, req_write, req_sel;
    logic [DATA_W-1:0] req_data, rsp_data;
    logic              rsp_valid, rsp_err, busy, dir, sel;
    modport master (
        input  req_valid, req_write, req_data, req_sel,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy, dir, sel
    );
    modport slave (
        output req_valid, req_write, req_data, req_sel,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy, dir, sel
    );
endinterface

// File: rtl/io_bus_master.sv
// io_bus_master: master end of the bidirectional peripheral bus, single write/read transactions.
// Optional read pattern check enabled by defining IOBUS_RD_CHECK_EN.
module io_bus_master #(
    parameter int DATA_W   = 2,
    parameter int TURN_CYC = 1
) (
    input  logic             clock,
    input  logic             reset,
    inout  wire [DATA_W-1:0] dataBus,
    io_bus_master_if.master  host
);
    typedef enum logic [1:0] {IDLE, WR, RD} state_t;
    state_t            r_state, w_next;
    logic              r_dir, r_sel, r_first, r_rsp_valid;
    logic [1:0]        r_cnt;
    logic [DATA_W-1:0] r_hold, r_rsp_data;
    logic              w_accept, w_rd_done;
    always_ff @(posedge clock or posedge reset)
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    always_comb begin
        w_accept  = (r_state == IDLE) && host.req_valid;
        w_rd_done = (r_state == RD) && !r_first && (r_cnt == 2'd1);
        w_next    = w_accept ? (host.req_write ? WR : RD)
                  : ((r_state == WR) || w_rd_done) ? IDLE : r_state;
    end
    // The first RD edge belongs to the peripheral loading its pattern; counting starts after it.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            r_dir       <= 1'b1;
            r_sel       <= 1'b0;
            r_first     <= 1'b0;
            r_cnt       <= 2'd0;
            r_hold      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= (r_state == WR) || w_rd_done;
            if (w_accept && host.req_write) r_hold <= host.req_data;
            if (w_accept && !host.req_write) begin
                r_dir   <= 1'b0;
                r_sel   <= host.req_sel;
                r_cnt   <= 2'(TURN_CYC);
                r_first <= 1'b1;
            end
            if (r_state == RD) begin
                r_first <= 1'b0;
                if (!r_first) r_cnt <= r_cnt - 2'd1;
            end
            if (w_rd_done) begin
                r_rsp_data <= dataBus;
                r_dir      <= 1'b1;
            end
        end
    assign dataBus        = r_dir ? r_hold : 'z;
    assign host.dir       = r_dir;
    assign host.sel       = r_sel;
    assign host.req_ready = (r_state == IDLE);
    assign host.busy      = (r_state != IDLE);
    assign host.rsp_valid = r_rsp_valid;
    assign host.rsp_data  = r_rsp_data;
`ifdef IOBUS_RD_CHECK_EN
    logic              r_err;
    logic [DATA_W-1:0] w_pattern;
    assign w_pattern = r_sel ? DATA_W'(1) : DATA_W'(2);
    always_ff @(posedge clock or posedge reset)
        if (reset) r_err <= 1'b0;
        else       r_err <= w_rd_done && (dataBus != w_pattern);
    assign host.rsp_err = r_err;
`else
    assign host.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: two masters (TURN_CYC 1 and 3), each with a behavioural
// peripheral; responses are checked against a scoreboard of expected completions.
module tb_io_bus_master;
`ifdef IOBUS_RD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    typedef struct {int k; logic [1:0] data; logic err; int due;} exp_t;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;
    logic [1:0] req_valid = 2'b00;
    logic       req_write = 1'b0, req_sel = 1'b0, bad = 1'b0;
    logic [1:0] req_data = 2'b00;
    wire  [1:0] bus1, bus3;
    logic [1:0] pst1, pst3;
    logic [1:0] last_rd [2];
    logic [1:0] rv_v, err_v;
    logic [1:0] rd_v [2];
    exp_t       q[$];
    exp_t       m;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    io_bus_master_if #(.DATA_W(2)) h1 ();
    io_bus_master_if #(.DATA_W(2)) h3 ();
    io_bus_master #(.DATA_W(2), .TURN_CYC(1)) dut1 (.clock(clock), .reset(reset), .dataBus(bus1), .host(h1));
    io_bus_master #(.DATA_W(2), .TURN_CYC(3)) dut3 (.clock(clock), .reset(reset), .dataBus(bus3), .host(h3));
    assign h1.req_valid = req_valid[0];
    assign h3.req_valid = req_valid[1];
    assign h1.req_write = req_write;
    assign h3.req_write = req_write;
    assign h1.req_data  = req_data;
    assign h3.req_data  = req_data;
    assign h1.req_sel   = req_sel;
    assign h3.req_sel   = req_sel;
    assign rv_v  = {h3.rsp_valid, h1.rsp_valid};
    assign err_v = {h3.rsp_err, h1.rsp_err};
    assign rd_v[0] = h1.rsp_data;
    assign rd_v[1] = h3.rsp_data;
    // Peripherals: sample the bus while the master drives, otherwise present the selected pattern.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            pst1 <= 2'b00;
            pst3 <= 2'b00;
        end else begin
            pst1 <= h1.dir ? bus1 : (h1.sel ? 2'b01 : 2'b10);
            pst3 <= h3.dir ? bus3 : (h3.sel ? 2'b01 : 2'b10);
        end
    assign bus1 = h1.dir ? 2'bzz : (bad ? 2'b11 : pst1);
    assign bus3 = h3.dir ? 2'bzz : (bad ? 2'b11 : pst3);
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock)
        if (!reset)
            for (int k = 0; k < 2; k++) begin
                if (rv_v[k]) begin
                    vectors++;
                    if (q.size() == 0 || q[0].k != k) begin
                        miscompares++;
                        $display("FAIL unexpected_rsp dut%0d at cycle %0d", k, cyc);
                    end else begin
                        m = q.pop_front();
                        vectors += 3;
                        if (rd_v[k] !== m.data) begin
                            miscompares++;
                            $display("FAIL rsp_data dut%0d got %b exp %b", k, rd_v[k], m.data);
                        end
                        if (err_v[k] !== m.err) begin
                            miscompares++;
                            $display("FAIL rsp_err dut%0d got %b exp %b", k, err_v[k], m.err);
                        end
                        if (cyc !== m.due) begin
                            miscompares++;
                            $display("FAIL rsp_latency dut%0d got cycle %0d exp %0d", k, cyc, m.due);
                        end
                    end
                end else begin
                    vectors++;
                    if (err_v[k] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL err_idle dut%0d got %b exp 0", k, err_v[k]);
                    end
                end
            end
    task automatic issue(input int k, input logic w, input logic [1:0] d, input logic s);
        exp_t e;
        req_write = w;
        req_data = d;
        req_sel = s;
        req_valid[k] = 1'b1;
        if (!w) last_rd[k] = bad ? 2'b11 : (s ? 2'b01 : 2'b10);
        e.k = k;
        e.data = last_rd[k];
        e.err = CHK && !w && bad;
        e.due = cyc + 2 + (w ? 0 : (k == 1 ? 3 : 1));
        q.push_back(e);
        @(negedge clock);
        req_valid[k] = 1'b0;
    endtask
    task automatic test_reset;
        #3 reset = 1'b1;
        #1;
        vectors += 4;
        if (h1.dir !== 1'b1 || h3.dir !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_dir got %b%b exp 11", h3.dir, h1.dir);
        end
        if (bus1 !== 2'b00 || bus3 !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_bus got %b/%b exp 00/00", bus1, bus3);
        end
        if (h1.req_ready !== 1'b1 || h1.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready got ready=%b busy=%b exp 1/0", h1.req_ready, h1.busy);
        end
        if (rv_v !== 2'b00 || rd_v[0] !== 2'b00 || h1.sel !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rsp got valid=%b data=%b sel=%b exp 00/00/0", rv_v, rd_v[0], h1.sel);
        end
        @(negedge clock);
        reset = 1'b0;
        last_rd[0] = 2'b00;
        last_rd[1] = 2'b00;
        @(negedge clock);
        vectors++;
        if (pst1 !== 2'b00 || pst3 !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_periph got %b/%b exp 00/00", pst1, pst3);
        end
    endtask
    task automatic test_write;
        issue(0, 1'b1, 2'b11, 1'b0);
        vectors += 2;
        if (bus1 !== 2'b11 || h1.dir !== 1'b1) begin
            miscompares++;
            $display("FAIL write_bus got bus=%b dir=%b exp 11/1", bus1, h1.dir);
        end
        if (h1.busy !== 1'b1 || h1.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL write_busy got busy=%b ready=%b exp 1/0", h1.busy, h1.req_ready);
        end
        @(negedge clock);
        vectors += 2;
        if (pst1 !== 2'b11) begin
            miscompares++;
            $display("FAIL write_periph got %b exp 11", pst1);
        end
        if (h1.req_ready !== 1'b1 || h1.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL write_done got ready=%b busy=%b exp 1/0", h1.req_ready, h1.busy);
        end
        @(negedge clock);
    endtask
    task automatic test_read_t1;
        issue(0, 1'b0, 2'b00, 1'b1);
        vectors++;
        if (h1.dir !== 1'b0 || h1.sel !== 1'b1) begin
            miscompares++;
            $display("FAIL read_dir0 got dir=%b sel=%b exp 0/1", h1.dir, h1.sel);
        end
        req_write = 1'b1;
        req_data = 2'b00;
        req_valid[0] = 1'b1;
        @(negedge clock);
        req_valid[0] = 1'b0;
        vectors++;
        if (h1.dir !== 1'b0) begin
            miscompares++;
            $display("FAIL read_dir1 got %b exp 0", h1.dir);
        end
        @(negedge clock);
        vectors++;
        if (h1.dir !== 1'b1 || bus1 !== 2'b11 || h1.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL read_return got dir=%b bus=%b ready=%b exp 1/11/1", h1.dir, bus1, h1.req_ready);
        end
        @(negedge clock);
        vectors++;
        if (pst1 !== 2'b11) begin
            miscompares++;
            $display("FAIL read_revert got %b exp 11", pst1);
        end
    endtask
    task automatic test_back_to_back;
        issue(1, 1'b0, 2'b00, 1'b0);
        repeat (3) @(negedge clock);
        vectors++;
        if (h3.dir !== 1'b0 || h3.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_turn got dir=%b busy=%b exp 0/1", h3.dir, h3.busy);
        end
        @(negedge clock);
        vectors++;
        if (h3.rsp_valid !== 1'b1 || h3.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready got valid=%b ready=%b exp 1/1", h3.rsp_valid, h3.req_ready);
        end
        issue(1, 1'b1, 2'b01, 1'b0);
        vectors++;
        if (h3.busy !== 1'b1 || bus3 !== 2'b01 || h3.dir !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept got busy=%b bus=%b dir=%b exp 1/01/1", h3.busy, bus3, h3.dir);
        end
        @(negedge clock);
        vectors++;
        if (pst3 !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_periph got %b exp 01", pst3);
        end
        @(negedge clock);
    endtask
    task automatic test_reset_mid_read;
        issue(0, 1'b0, 2'b00, 1'b0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        void'(q.pop_back());
        last_rd[0] = 2'b00;
        last_rd[1] = 2'b00;
        vectors++;
        if (h1.dir !== 1'b1 || bus1 !== 2'b00 || h1.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_state got dir=%b bus=%b ready=%b exp 1/00/1", h1.dir, bus1, h1.req_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        issue(0, 1'b0, 2'b00, 1'b1);
        repeat (2) @(negedge clock);
        vectors++;
        if (h1.dir !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_next_dir got %b exp 1", h1.dir);
        end
        @(negedge clock);
    endtask
    task automatic test_rd_check;
        bad = 1'b1;
        issue(0, 1'b0, 2'b00, 1'b1);
        repeat (2) @(negedge clock);
        bad = 1'b0;
        @(negedge clock);
        bad = 1'b1;
        issue(1, 1'b0, 2'b00, 1'b0);
        repeat (4) @(negedge clock);
        bad = 1'b0;
        @(negedge clock);
    endtask
    initial begin
        test_reset;
        test_write;
        test_read_t1;
        test_back_to_back;
        test_reset_mid_read;
        test_rd_check;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_rsp got %0d pending exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
